// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream bandwidth checker and its
// companion pattern generator.
package axis_chk_pkg;

  localparam int          LANE_W       = 32;
  localparam logic [31:0] ERR_IDX_NONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  // Status counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axis_bw_checker_if.sv
// AXI-Stream beat channel between a read master and the bandwidth checker.
// Handshake: a beat transfers on a clock edge where tvalid and tready are both high;
// tready may depend only on the sink's registered state, never on tvalid.
interface axis_bw_checker_if #(
  parameter int DATA_WIDTH = 64
);
  logic                    tvalid;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic                    tready;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axis_pattern_ref.sv
// Expected-data generator: 32-bit lanes counting up from the seed, shared with
// the write-stream generator so both sides agree on the pattern.
module axis_pattern_ref
  import axis_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [31:0]           seed,
  input  logic [31:0]           beat_idx,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int NLANES = DATA_WIDTH / LANE_W;

  logic [31:0] base;

  // All arithmetic is modulo 2^32, so the pattern wraps naturally.
  always_comb begin
    base = seed + beat_idx * 32'(NLANES);
    data = '0;
    for (int k = 0; k < NLANES; k++) begin
      data[k*LANE_W +: LANE_W] = base + 32'(k);
    end
  end

endmodule

// File: rtl/axis_bw_checker.sv
// Sink-side AXI-Stream checker: applies a programmable tready duty pattern,
// compares beats against the seeded pattern and reports counts and timing.
module axis_bw_checker
  import axis_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BP_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                rstn,
  axis_bw_checker_if.slave    s_axis,
  input  logic                START_REG,
  input  logic [31:0]         SEED_REG,
  input  logic [31:0]         NBEATS_REG,
  input  logic [BP_WIDTH-1:0] BP_MASK_REG,
  output logic                BUSY_REG,
  output logic                DONE_REG,
  output logic [31:0]         BEAT_CNT_REG,
  output logic [31:0]         ERR_CNT_REG,
  output logic [31:0]         CYCLE_CNT_REG,
  output logic [31:0]         TLAST_CNT_REG,
  output logic [31:0]         FIRST_ERR_IDX_REG,
  output chk_state_e          dbg_state
);

  localparam int PH_W   = (BP_WIDTH > 1) ? $clog2(BP_WIDTH) : 1;
  localparam int NBYTES = DATA_WIDTH / 8;

  chk_state_e          state_q, state_d;
  logic                start_q;
  logic [31:0]         seed_l, nbeats_l;
  logic [BP_WIDTH-1:0] mask_l;
  logic [PH_W-1:0]     phase;
  logic [31:0]         beat_idx;
  logic [31:0]         beat_cnt, err_cnt, cycle_cnt, tlast_cnt, first_err;

  logic                  active, rdy, accept, start_go, last_beat, beat_err;
  logic [DATA_WIDTH-1:0] exp_data;

  axis_pattern_ref #(.DATA_WIDTH(DATA_WIDTH)) u_ref (
    .seed     (seed_l),
    .beat_idx (beat_idx),
    .data     (exp_data)
  );

  assign active    = (state_q == ST_ARMED) || (state_q == ST_RUN);
  // A zero-beat run must never assert tready during its single ARMED cycle.
  assign rdy       = active && (nbeats_l != 32'd0) && mask_l[phase];
  assign accept    = s_axis.tvalid && rdy;
  assign start_go  = START_REG && !start_q &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_beat = (beat_idx == nbeats_l - 32'd1);

  // Only strobed bytes take part in the comparison.
  always_comb begin
    beat_err = 1'b0;
    for (int b = 0; b < NBYTES; b++) begin
      if (s_axis.tstrb[b] && (s_axis.tdata[8*b +: 8] != exp_data[8*b +: 8])) begin
        beat_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_go) state_d = ST_ARMED;
      ST_ARMED: begin
        if (nbeats_l == 32'd0)      state_d = ST_DONE;
        else if (accept)            state_d = last_beat ? ST_DONE : ST_RUN;
      end
      ST_RUN:   if (accept && last_beat) state_d = ST_DONE;
      ST_DONE:  if (start_go) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q   <= 1'b0;
      seed_l    <= '0;
      nbeats_l  <= '0;
      mask_l    <= '0;
      phase     <= '0;
      beat_idx  <= '0;
      beat_cnt  <= '0;
      err_cnt   <= '0;
      cycle_cnt <= '0;
      tlast_cnt <= '0;
      first_err <= ERR_IDX_NONE;
    end else begin
      start_q <= START_REG;
      if (start_go) begin
        seed_l    <= SEED_REG;
        nbeats_l  <= NBEATS_REG;
        mask_l    <= (BP_MASK_REG == '0) ? '1 : BP_MASK_REG;
        phase     <= '0;
        beat_idx  <= '0;
        beat_cnt  <= '0;
        err_cnt   <= '0;
        cycle_cnt <= '0;
        tlast_cnt <= '0;
        first_err <= ERR_IDX_NONE;
      end else begin
        if (active) begin
          phase <= (phase == PH_W'(BP_WIDTH - 1)) ? '0 : phase + 1'b1;
        end
        if (accept) begin
          beat_idx <= beat_idx + 32'd1;
          beat_cnt <= sat_inc(beat_cnt);
          if (s_axis.tlast) tlast_cnt <= sat_inc(tlast_cnt);
          if (beat_err) begin
            err_cnt <= sat_inc(err_cnt);
            if (err_cnt == 32'd0) first_err <= beat_idx;
          end
        end
        // The window opens on the first accepted beat and closes with the last.
        if ((state_q == ST_ARMED) && accept) begin
          cycle_cnt <= 32'd1;
        end else if (state_q == ST_RUN) begin
          cycle_cnt <= sat_inc(cycle_cnt);
        end
      end
    end
  end

  assign s_axis.tready     = rdy;
  assign BUSY_REG          = active;
  assign DONE_REG          = (state_q == ST_DONE);
  assign BEAT_CNT_REG      = beat_cnt;
  assign ERR_CNT_REG       = err_cnt;
  assign CYCLE_CNT_REG     = cycle_cnt;
  assign TLAST_CNT_REG     = tlast_cnt;
  assign FIRST_ERR_IDX_REG = first_err;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_axis_bw_checker.sv
// Directed bench for axis_bw_checker: drives seeded streams under several
// tready masks and checks the status registers against hand-computed values.
module tb_axis_bw_checker;
  import axis_chk_pkg::*;

  localparam int DW  = 64;
  localparam int BPW = 8;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start_reg;
  logic [31:0]    seed_reg, nbeats_reg;
  logic [BPW-1:0] bp_mask_reg;
  logic           busy, done;
  logic [31:0]    beat_cnt, err_cnt, cycle_cnt, tlast_cnt, first_err;
  chk_state_e     dbg_state;

  axis_bw_checker_if #(.DATA_WIDTH(DW)) s_axis ();

  axis_bw_checker #(.DATA_WIDTH(DW), .BP_WIDTH(BPW)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .s_axis            (s_axis),
    .START_REG         (start_reg),
    .SEED_REG          (seed_reg),
    .NBEATS_REG        (nbeats_reg),
    .BP_MASK_REG       (bp_mask_reg),
    .BUSY_REG          (busy),
    .DONE_REG          (done),
    .BEAT_CNT_REG      (beat_cnt),
    .ERR_CNT_REG       (err_cnt),
    .CYCLE_CNT_REG     (cycle_cnt),
    .TLAST_CNT_REG     (tlast_cnt),
    .FIRST_ERR_IDX_REG (first_err),
    .dbg_state         (dbg_state)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          rdy_hi, rdy_lo;
  logic [63:0] tbl [2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [31:0] beat, input logic [31:0] err,
                            input logic [31:0] cyc, input logic [31:0] tl,
                            input logic [31:0] first, input logic b, input logic d);
    check({tag, ".beat"},  beat_cnt,  beat);
    check({tag, ".err"},   err_cnt,   err);
    check({tag, ".cycle"}, cycle_cnt, cyc);
    check({tag, ".tlast"}, tlast_cnt, tl);
    check({tag, ".first"}, first_err, first);
    check({tag, ".busy"},  32'(busy), 32'(b));
    check({tag, ".done"},  32'(done), 32'(d));
  endtask

  // Two 32-bit lanes per beat: {seed+2i+1, seed+2i}, modulo 2^32.
  function automatic logic [63:0] tb_pattern(input logic [31:0] seed, input int i);
    logic [31:0] b;
    b = seed + 32'(2 * i);
    return {b + 32'd1, b};
  endfunction

  // Returns just after the edge that sees the START rise.
  task automatic do_start(input logic [31:0] seed, input logic [31:0] n, input logic [7:0] mask);
    @(negedge clk);
    seed_reg    = seed;
    nbeats_reg  = n;
    bp_mask_reg = mask;
    start_reg   = 1'b1;
    @(posedge clk);
  endtask

  // Feeds beats until 'stop' are accepted; tready is sampled at the negedge.
  task automatic stream(input string tag, input int n, input int stop, input logic [31:0] seed,
                        input int pulse_at, input int bad_a, input logic [63:0] xor_a,
                        input int bad_b, input logic [63:0] xor_b, input logic [7:0] strb_b,
                        input bit use_tbl);
    int   i;
    int   cyc;
    logic rdy;
    i = 0;
    cyc = 0;
    rdy_hi = 0;
    rdy_lo = 0;
    while (i < stop && cyc < 200) begin
      @(negedge clk);
      start_reg     = (i == pulse_at);
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = (use_tbl ? tbl[i] : tb_pattern(seed, i))
                      ^ ((i == bad_a) ? xor_a : 64'd0) ^ ((i == bad_b) ? xor_b : 64'd0);
      s_axis.tstrb  = (i == bad_b) ? strb_b : 8'hFF;
      s_axis.tlast  = (i == n - 1);
      rdy = s_axis.tready;
      if (rdy) rdy_hi++; else rdy_lo++;
      @(posedge clk);
      if (rdy) i++;
      cyc++;
    end
    check({tag, ".fed"}, 32'(i), 32'(stop));
    @(negedge clk);
    start_reg     = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  initial begin
    start_reg     = 1'b0;
    seed_reg      = '0;
    nbeats_reg    = '0;
    bp_mask_reg   = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tstrb  = '0;
    s_axis.tlast  = 1'b0;
    tbl[0]        = 64'hFFFFFFFF_FFFFFFFE;
    tbl[1]        = 64'h00000001_00000000;

    // Reset values, then no acceptance without a START edge.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_regs("reset", 0, 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("reset.tready", 32'(s_axis.tready), 0);
    check("reset.state", 32'(dbg_state), 32'(ST_IDLE));
    rstn = 1'b1;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = tb_pattern(32'h0, 0);
    s_axis.tstrb  = 8'hFF;
    repeat (3) @(negedge clk);
    check("nostart.tready", 32'(s_axis.tready), 0);
    check("nostart.beat", beat_cnt, 0);
    s_axis.tvalid = 1'b0;

    // Full-rate run.
    do_start(32'h100, 16, 8'hFF);
    stream("full", 16, 16, 32'h100, -1, -1, 64'd0, -1, 64'd0, 8'hFF, 1'b0);
    check_regs("full", 16, 0, 16, 1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check("full.rdy_lo", 32'(rdy_lo), 0);
    repeat (2) @(negedge clk);
    check("full.done_hold", 32'(done), 1);
    check("full.state", 32'(dbg_state), 32'(ST_DONE));

    // Half-rate backpressure: tready alternates starting high.
    do_start(32'h100, 16, 8'h55);
    stream("half", 16, 16, 32'h100, -1, -1, 64'd0, -1, 64'd0, 8'hFF, 1'b0);
    check_regs("half", 16, 0, 31, 1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check("half.rdy_hi", 32'(rdy_hi), 16);
    check("half.rdy_lo", 32'(rdy_lo), 15);

    // Beat 5 has a bad upper lane; beat 9 has a bad byte 0 that is not strobed.
    do_start(32'h100, 16, 8'hFF);
    stream("corrupt", 16, 16, 32'h100, -1, 5, 64'h0001_0000_0000_0000,
           9, 64'h0000_0000_0000_00FF, 8'hFE, 1'b0);
    check_regs("corrupt", 16, 1, 16, 1, 5, 1'b0, 1'b1);

    // Zero-beat run finishes without ever raising tready.
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = tb_pattern(32'h0, 0);
    s_axis.tstrb  = 8'hFF;
    do_start(32'h0, 0, 8'hFF);
    @(negedge clk);
    start_reg = 1'b0;
    check("zero.armed_done", 32'(done), 0);
    check("zero.armed_busy", 32'(busy), 1);
    check("zero.armed_tready", 32'(s_axis.tready), 0);
    @(negedge clk);
    check_regs("zero", 0, 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check("zero.tready", 32'(s_axis.tready), 0);
    s_axis.tvalid = 1'b0;

    // Reset mid-run after 7 beats, then a short run with an all-zero mask.
    do_start(32'h200, 16, 8'hFF);
    stream("pre_rst", 16, 7, 32'h200, -1, -1, 64'd0, -1, 64'd0, 8'hFF, 1'b0);
    check("pre_rst.beat", beat_cnt, 7);
    rstn = 1'b0;
    #1;
    check_regs("midrst", 0, 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("midrst.tready", 32'(s_axis.tready), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    s_axis.tvalid = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst.tready", 32'(s_axis.tready), 0);
    check("postrst.beat", beat_cnt, 0);
    s_axis.tvalid = 1'b0;
    do_start(32'h300, 4, 8'h00);
    stream("restart", 4, 4, 32'h300, -1, -1, 64'd0, -1, 64'd0, 8'hFF, 1'b0);
    check_regs("restart", 4, 0, 4, 1, 32'hFFFF_FFFF, 1'b0, 1'b1);

    // Seed near the top wraps lanes; a START pulse during the run is ignored.
    do_start(32'hFFFF_FFFE, 2, 8'h55);
    stream("wrap", 2, 2, 32'hFFFF_FFFE, 1, -1, 64'd0, -1, 64'd0, 8'hFF, 1'b1);
    check_regs("wrap", 2, 0, 3, 1, 32'hFFFF_FFFF, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_bw_checker.md
AXIS_BW_CHECKER -- requirements
Module: axis_bw_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, AXIS data width; a multiple of 32.
REQ-002 SHALL have parameter BP_WIDTH, default 8, backpressure mask length.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk  in  1  clock; rstn  in  1  async reset, active low.
REQ-004 SHALL have port s_axis_tvalid  in  1  beat valid, driven by the read master's m_axis_tvalid.
REQ-005 SHALL have port s_axis_tdata  in  DATA_WIDTH  beat data.
REQ-006 SHALL have port s_axis_tstrb  in  DATA_WIDTH/8  byte strobes.
REQ-007 SHALL have port s_axis_tlast  in  1  last flag; counted only.
REQ-008 SHALL have port s_axis_tready  out  1  accept.
REQ-009 SHALL have port START_REG  in  1  start; rising-edge sensitive.
REQ-010 SHALL have port SEED_REG  in  32  pattern seed.
REQ-011 SHALL have port NBEATS_REG  in  32  beats to check.
REQ-012 SHALL have port BP_MASK_REG  in  BP_WIDTH  tready duty pattern.
REQ-013 SHALL have port BUSY_REG  out  1  checker active.
REQ-014 SHALL have port DONE_REG  out  1  run complete.
REQ-015 SHALL have ports BEAT_CNT_REG, ERR_CNT_REG, CYCLE_CNT_REG, TLAST_CNT_REG, FIRST_ERR_IDX_REG  out  32 each: accepted beats, mismatching beats, cycles first-to-last beat inclusive, tlast beats, index of first bad beat.

Function
REQ-016 SHALL have FSM states IDLE, ARMED, RUN, DONE.
REQ-017 SHALL sample START_REG into a register; a rising edge in IDLE or DONE clears all counters, latches SEED/NBEATS/BP_MASK, and moves to ARMED.
REQ-018 SHALL ignore START rising edges in ARMED or RUN.
REQ-019 SHALL, when the latched NBEATS = 0, go from ARMED to DONE on the next cycle with all counts 0.
REQ-020 SHALL drive s_axis_tready = (ARMED or RUN) AND mask[phase], where phase is a mod-BP_WIDTH counter that resets to 0 on start and advances every cycle in ARMED/RUN.
REQ-021 SHALL treat a latched mask of all zeros as all ones, to avoid deadlock.
REQ-022 SHALL count a beat as accepted only when tvalid and tready are both high in the same cycle.
REQ-023 SHALL move ARMED to RUN on the first accepted beat; CYCLE_CNT becomes 1 on that cycle and increments every cycle through the final accepted beat inclusive.
REQ-024 SHALL compute the expected data of beat i as 32-bit lanes k = 0..DATA_WIDTH/32-1, each equal to SEED + i*(DATA_WIDTH/32) + k mod 2^32.
REQ-025 SHALL flag a beat as an error if any byte with tstrb = 1 differs from the expected data; bytes with tstrb = 0 are not compared, and an all-zero strobe is never an error.
REQ-026 SHALL, on the first error of a run, latch the beat index in FIRST_ERR_IDX; FIRST_ERR_IDX = 0xFFFFFFFF when the run has no error.
REQ-027 SHALL move RUN to DONE on the cycle after the beat with index NBEATS-1 is accepted; tready is low in DONE.
REQ-028 SHALL update all outputs registered, one cycle after the accepting edge.
REQ-029 SHALL saturate every counter at 0xFFFFFFFF; the beat index driving the pattern wraps mod 2^32.
REQ-030 SHALL drive BUSY = ARMED or RUN and DONE = DONE state; DONE holds until the next start.

Reset
REQ-031 SHALL, on rstn low at any time including mid-run, enter IDLE with tready = 0, BUSY = 0, DONE = 0, all counters 0, FIRST_ERR_IDX = 0xFFFFFFFF, phase 0, and the START edge register 0.
REQ-032 SHALL require a fresh START rising edge after reset release before any beat is accepted.

Structure
REQ-033 SHALL place the FSM state enum, LANE_W = 32 and the ERR_IDX_NONE = 0xFFFFFFFF constant in shared package axis_chk_pkg.
REQ-034 SHALL implement expected-data generation in sub-module axis_pattern_ref (inputs seed and beat index, output DATA_WIDTH word), reusable by the upstream write-stream generator.

Verification
REQ-035 SHALL check: SEED = 0x100, NBEATS = 16, mask 0xFF, source always valid with the correct pattern -> BEAT = 16, ERR = 0, CYCLE = 16, FIRST_ERR = 0xFFFFFFFF, DONE = 1.
REQ-036 SHALL check: same run with mask 0x55 -> tready toggles every cycle, BEAT = 16, CYCLE = 31, ERR = 0.
REQ-037 SHALL check: beat 5 upper lane corrupted, then beat 9 byte 0 corrupted with tstrb[0] = 0 -> ERR = 1, FIRST_ERR = 5.
REQ-038 SHALL check: NBEATS = 0 -> DONE 2 cycles after the START edge, tready never high, all counts 0.
REQ-039 SHALL check: rstn low after beat 7 of 16 -> all outputs at reset values; a new START with NBEATS = 4 gives BEAT = 4, ERR = 0.
REQ-040 SHALL check: SEED = 0xFFFFFFFE, NBEATS = 2 -> expected lanes 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001 (wrap), ERR = 0; START pulsed mid-run is ignored.
